// File: rtl/fir_filter_serial.sv
// Time-multiplexed FIR filter: one MAC unit walks a TAPS-deep delay line against a
// runtime-writable coefficient bank, producing one full-precision result per accepted sample.
module fir_filter_serial #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 8,
  parameter int AW     = $clog2(TAPS),
  parameter int OUT_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     coef_we,
  input  logic        [AW-1:0]     coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_data
);

  localparam int PW = DATA_W + COEF_W;
  localparam logic [AW:0]   TAPS_CNT = (AW + 1)'(TAPS);
  localparam logic [AW-1:0] LAST     = AW'(TAPS - 1);

  typedef enum logic {IDLE, MAC} state_t;

  state_t                   state;
  logic signed [DATA_W-1:0] x [TAPS];
  logic signed [COEF_W-1:0] h [TAPS];
  logic        [AW-1:0]     idx;
  logic signed [OUT_W-1:0]  acc;
  logic signed [OUT_W-1:0]  acc_next;
  logic signed [PW-1:0]     x_ext;
  logic signed [PW-1:0]     h_ext;
  logic signed [PW-1:0]     prod;

  assign in_ready = (state == IDLE);

  // Single shared multiplier; the product is sign-extended so the sum never wraps.
  always_comb begin
    x_ext    = PW'(x[idx]);
    h_ext    = PW'(h[idx]);
    prod     = x_ext * h_ext;
    acc_next = acc + OUT_W'(prod);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < TAPS; i++) begin
        x[i] <= '0;
        h[i] <= '0;
      end
      h[0] <= COEF_W'(1);
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Coefficient writes are only honoured between computations.
          if (coef_we && ({1'b0, coef_addr} < TAPS_CNT)) begin
            h[coef_addr] <= coef_data;
          end
          if (in_valid) begin
            for (int i = TAPS - 1; i > 0; i--) begin
              x[i] <= x[i-1];
            end
            x[0]  <= in_data;
            idx   <= '0;
            acc   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          if (idx == LAST) begin
            out_data  <= acc_next;
            out_valid <= 1'b1;
            idx       <= '0;
            state     <= IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_filter_serial.sv
// Directed bench for fir_filter_serial: a reference model pushes expected results into a
// scoreboard on every accepted sample and a monitor pops them when the filter pulses out_valid.
module tb_fir_filter_serial;

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int TAPS   = 8;
  localparam int AW     = 3;
  localparam int OUT_W  = DATA_W + COEF_W + 3;

  logic                     clk;
  logic                     reset;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     coef_we;
  logic        [AW-1:0]     coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  out_data;

  int     n_cmp  = 0;
  int     n_fail = 0;
  int     n_acc  = 0;
  longint last_out = 0;

  int     m_x [TAPS];
  int     m_h [TAPS];
  int     m_cnt  = 0;
  bit     m_due  = 1'b0;
  longint m_hold = 0;
  longint sb [$];

  fir_filter_serial #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W),
    .TAPS  (TAPS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .coef_we  (coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .out_valid(out_valid),
    .out_data (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic signed [63:0] obs,
                              input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: tracks its own busy window and predicts every result.
  always @(posedge clk or posedge reset) begin
    longint y;
    m_due = 1'b0;
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        m_x[i] = 0;
        m_h[i] = (i == 0) ? 1 : 0;
      end
      m_cnt = 0;
    end else if (m_cnt == 0) begin
      if (coef_we === 1'b1) m_h[coef_addr] = int'(coef_data);
      if (in_valid === 1'b1) begin
        for (int i = TAPS - 1; i > 0; i--) m_x[i] = m_x[i-1];
        m_x[0] = int'(in_data);
        y = 0;
        for (int i = 0; i < TAPS; i++) y += longint'(m_x[i]) * longint'(m_h[i]);
        sb.push_back(y);
        m_cnt = TAPS;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) m_due = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (!reset && in_valid && in_ready) n_acc++;
  end

  // Monitor: sample outputs on the falling edge, pop the scoreboard on each pulse.
  always @(negedge clk) begin
    longint e;
    if (reset) begin
      sb.delete();
      m_hold = 0;
    end
    check_output("in_ready", in_ready, 64'(m_cnt == 0));
    check_output("out_valid", out_valid, 64'(m_due));
    if (out_valid === 1'b1) begin
      check_output("result_pending", 64'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        m_hold = e;
        check_output("out_data_pulse", out_data, e);
        last_out = longint'(out_data);
      end
    end else begin
      check_output("out_data_hold", out_data, m_hold);
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(m_cnt == 0 && sb.size() == 0) && n < 40);
    check_output("idle_timeout", 64'(m_cnt == 0 && sb.size() == 0), 1);
  endtask

  task automatic apply_stimulus(input int v);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = v[DATA_W-1:0];
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle();
  endtask

  task automatic write_coef(input int a, input int v);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = a[AW-1:0];
    coef_data = v[COEF_W-1:0];
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  initial begin
    int imp_exp [4];
    int acc_before;
    imp_exp = '{1, 2, 1, 0};
    in_valid  = 1'b0;
    in_data   = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    reset     = 1'b0;
    #1 reset  = 1'b1;
    repeat (2) @(negedge clk);
    check_output("reset_out_valid", out_valid, 0);
    check_output("reset_out_data", out_data, 0);
    check_output("reset_in_ready", in_ready, 1);
    reset = 1'b0;

    $display("[TB] pass-through after reset");
    apply_stimulus(5);
    check_output("passthru_5", last_out, 5);
    apply_stimulus(-3);
    check_output("passthru_m3", last_out, -3);

    $display("[TB] impulse response");
    write_coef(1, 2);
    write_coef(2, 1);
    for (int i = 0; i < TAPS; i++) apply_stimulus(0);
    apply_stimulus(1);
    check_output("impulse_0", last_out, imp_exp[0]);
    for (int i = 1; i < 4; i++) begin
      apply_stimulus(0);
      check_output("impulse_n", last_out, imp_exp[i]);
    end

    $display("[TB] extreme values");
    for (int i = 0; i < TAPS; i++) write_coef(i, 127);
    for (int i = 0; i < TAPS; i++) apply_stimulus(-128);
    check_output("extreme_full", last_out, -130048);

    write_coef(0, 1);
    for (int i = 1; i < TAPS; i++) write_coef(i, 0);

    $display("[TB] backpressure");
    acc_before = n_acc;
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(10 + i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle();
    check_output("bp_accepts", n_acc - acc_before, 3);
    check_output("bp_last", last_out, 28);

    $display("[TB] coefficient write while busy");
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'sd3;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 8'sd4;
    @(negedge clk);
    coef_we = 1'b0;
    wait_idle();
    check_output("busy_write_result", last_out, 3);
    apply_stimulus(1);
    check_output("busy_write_dropped", last_out, 1);

    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 8'sd4;
    in_valid  = 1'b1;
    in_data   = 8'sd1;
    @(negedge clk);
    coef_we  = 1'b0;
    in_valid = 1'b0;
    wait_idle();
    check_output("idle_write_with_sample", last_out, 4);

    $display("[TB] reset mid-computation");
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'sd9;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check_output("midreset_out_data", out_data, 0);
    check_output("midreset_out_valid", out_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_output("midreset_no_pulse_data", out_data, 0);
    apply_stimulus(7);
    check_output("after_reset_7", last_out, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_filter_serial.md
# fir_filter_serial

Parametrised, time-multiplexed FIR filter: a TAPS-deep signed delay line, a runtime-loadable coefficient bank and one multiply-accumulate unit. Each accepted sample takes TAPS MAC cycles and produces one full-precision result. It is the next generation of the fixed 3-tap filter, adding generic width and depth, run-time coefficients and a valid/ready input handshake. It sits in the sample datapath between an upstream sample source and downstream consumers that accept a one-cycle valid pulse.

## Interface
- DATA_W, 8, input sample width, signed two's complement
- COEF_W, 8, coefficient width, signed two's complement
- TAPS, 8, number of taps (≥2)
- AW, $clog2(TAPS), coefficient address width (derived)
- OUT_W, DATA_W+COEF_W+$clog2(TAPS), result width (derived)
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  in_data is valid
- in_ready  out  1  block can accept a sample (high only in IDLE)
- in_data  in  DATA_W  signed input sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  AW  tap index to write
- coef_data  in  COEF_W  signed coefficient value
- out_valid  out  1  one-cycle pulse marking out_data as new
- out_data  out  OUT_W  signed filter result; held between pulses

## Operation
- Delay line x[0..TAPS-1], with x[0] the newest sample. Coefficients h[0..TAPS-1].
- Result: y = Σ h[i]·x[i], computed in full precision. Signed multiply, sign-extended to OUT_W, no rounding, no saturation. OUT_W is wide enough that overflow cannot occur.
- FSM has two states, IDLE and MAC.
  - IDLE: in_ready=1. On in_valid&&in_ready: shift the delay line (x[i]<=x[i-1], x[0]<=in_data), set idx<=0, acc<=0, go to MAC.
  - MAC: in_ready=0. Each cycle: acc<=acc+h[idx]·x[idx], idx<=idx+1.
  - When idx==TAPS-1: out_data<=acc+h[idx]·x[idx], out_valid<=1, return to IDLE.
- in_valid while in MAC is not consumed. Upstream must hold the sample until in_ready is seen high.
- Coefficient writes:
  - In IDLE with coef_we=1: h[coef_addr]<=coef_data.
  - coef_addr≥TAPS: write ignored.
  - coef_we while in MAC: write dropped, so a result never mixes old and new coefficient sets.
  - A write and a sample acceptance in the same IDLE cycle are both performed. The new coefficient applies to that sample.
- Reset values:
  - state=IDLE, in_ready=1.
  - out_valid=0, out_data=0, acc=0, idx=0.
  - All x[i]=0.
  - h[0]=1, all other h=0, so the block powers up as pass-through.
- Reset asserted mid-MAC: the computation is aborted, no out_valid is produced, and every register returns to its reset value, including coefficients.

## Timing
- Acceptance edge is E0. MAC products are added at edges E1..E_TAPS.
- out_valid is high for exactly the one cycle following edge E_TAPS. out_data updates at the same edge.
- in_ready rises in the same cycle as out_valid, so the earliest next acceptance is E_{TAPS+1}.
- Latency is TAPS cycles, sample to result. Maximum throughput is one sample per TAPS+1 cycles.
- out_valid is never high for two consecutive cycles.
- No combinational path from any input to any output. in_ready depends only on the state register.

## Test plan
- **Reset defaults, pass-through.** Release reset: out_valid=0, out_data=0, in_ready=1. Send 5, then -3 (TAPS=8): out_valid 8 cycles after each acceptance, with out_data=5 then -3.
- **Impulse response.** Load h={1,2,1,0,0,0,0,0}, then send 1,0,0,0: outputs 1,2,1,0.
- **Extreme values.** Load all h=127 and send -128 eight times: 8th result = -130048 (OUT_W=19), with no wrap.
- **Backpressure.** Hold in_valid=1 with a new value every cycle: exactly one acceptance per 9 cycles. in_ready is low during MAC, and only values present on acceptance edges appear in results.
- **Coefficient write while busy.** Set h[0]=1 and write h[0]=4 in MAC cycle 3: the current result uses h[0]=1. A readback impulse confirms the write was dropped. The same write in IDLE takes effect.
- **Reset mid-computation.** Assert reset in MAC cycle 4: no out_valid, out_data=0, coefficients back to pass-through. The next sample 7 returns 7.
